// File: rtl/spi_timer_pkg.sv
// Shared types for the programmable SPI delay timer.
package spi_timer_pkg;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      RUN  = 2'd1,
      DONE = 2'd2
   } timer_state_e;

endpackage

// File: rtl/spi_prescaler.sv
// Clock prescaler: pulses tick_o on every (prescale_i+1)-th enabled cycle.
module spi_prescaler #(
   parameter int PRESCALE_WIDTH = 8
) (
   input  logic                      clock_i,
   input  logic                      reset_ni,
   input  logic                      clear_i,
   input  logic                      en_i,
   input  logic [PRESCALE_WIDTH-1:0] prescale_i,
   output logic                      tick_o
);

   logic [PRESCALE_WIDTH-1:0] cnt_q;

   // Counter clears on its own tick, so it never wraps past prescale_i.
   assign tick_o = en_i && (cnt_q == prescale_i);

   always_ff @(posedge clock_i or negedge reset_ni) begin
      if (!reset_ni) begin
         cnt_q <= '0;
      end else if (clear_i) begin
         cnt_q <= '0;
      end else if (en_i) begin
         cnt_q <= tick_o ? '0 : cnt_q + PRESCALE_WIDTH'(1);
      end
   end

endmodule

// File: rtl/spi_prog_delay_timer.sv
// Run-time programmable delay timer for the SPI master: one-shot or periodic,
// abortable, with remaining-tick readout. Delay is formed by nested counters.
module spi_prog_delay_timer
   import spi_timer_pkg::*;
#(
   parameter int COUNT_WIDTH    = 16,
   parameter int PRESCALE_WIDTH = 8
) (
   input  logic                      clock_i,
   input  logic                      reset_ni,
   input  logic                      start_i,
   input  logic                      abort_i,
   input  logic [COUNT_WIDTH-1:0]    count_i,
   input  logic [PRESCALE_WIDTH-1:0] prescale_i,
   input  logic                      periodic_i,
   output logic                      busy_o,
   output logic                      done_o,
   output logic                      tick_o,
   output logic [COUNT_WIDTH-1:0]    remaining_o
);

   timer_state_e              state_q, state_d;
   logic [COUNT_WIDTH-1:0]    count_q;
   logic [PRESCALE_WIDTH-1:0] prescale_q;
   logic                      periodic_q;
   logic [COUNT_WIDTH-1:0]    remaining_d;
   logic                      busy_d, done_d, tick_d;
   logic                      launch, expire, pre_tick, pre_clear, pre_en;

   // Abort outranks both expiry and start; start is ignored while running.
   assign launch    = (state_q != RUN) && start_i && !abort_i;
   assign expire    = (state_q == RUN) && !abort_i &&
                      ((count_q == '0) || (pre_tick && (remaining_o == COUNT_WIDTH'(1))));
   assign pre_en    = (state_q == RUN);
   assign pre_clear = launch || abort_i || (expire && periodic_q);

   spi_prescaler #(
      .PRESCALE_WIDTH(PRESCALE_WIDTH)
   ) u_prescaler (
      .clock_i   (clock_i),
      .reset_ni  (reset_ni),
      .clear_i   (pre_clear),
      .en_i      (pre_en),
      .prescale_i(prescale_q),
      .tick_o    (pre_tick)
   );

   always_ff @(posedge clock_i or negedge reset_ni) begin
      if (!reset_ni) begin
         state_q <= IDLE;
      end else begin
         state_q <= state_d;
      end
   end

   always_comb begin
      state_d = state_q;
      unique case (state_q)
         IDLE: if (launch) state_d = RUN;
         RUN: begin
            if (abort_i)                   state_d = IDLE;
            else if (expire && !periodic_q) state_d = DONE;
         end
         DONE: begin
            if (abort_i)     state_d = IDLE;
            else if (launch) state_d = RUN;
         end
         default: state_d = IDLE;
      endcase
   end

   always_comb begin
      busy_d      = (state_d == RUN);
      done_d      = (state_d == DONE);
      tick_d      = expire;
      remaining_d = remaining_o;
      if (state_d != RUN) begin
         remaining_d = '0;
      end else if (launch) begin
         remaining_d = count_i;
      end else if (expire) begin
         remaining_d = count_q;
      end else if (pre_tick && (remaining_o != '0)) begin
         remaining_d = remaining_o - COUNT_WIDTH'(1);
      end
   end

   always_ff @(posedge clock_i or negedge reset_ni) begin
      if (!reset_ni) begin
         busy_o      <= 1'b0;
         done_o      <= 1'b0;
         tick_o      <= 1'b0;
         remaining_o <= '0;
         count_q     <= '0;
         prescale_q  <= '0;
         periodic_q  <= 1'b0;
      end else begin
         busy_o      <= busy_d;
         done_o      <= done_d;
         tick_o      <= tick_d;
         remaining_o <= remaining_d;
         if (launch) begin
            count_q    <= count_i;
            prescale_q <= prescale_i;
            periodic_q <= periodic_i;
         end
      end
   end

endmodule

// File: tb/tb_spi_prog_delay_timer.sv
// Self-checking bench: arithmetic reference model plus a small-width max-value run.
module tb_spi_prog_delay_timer;

   localparam int CW = 16;
   localparam int PW = 8;

   logic          clk = 1'b0;
   logic          rst_n = 1'b0;
   logic          start = 1'b0, abort = 1'b0, periodic = 1'b0;
   logic [CW-1:0] count = '0;
   logic [PW-1:0] prescale = '0;
   logic          busy, done, tick;
   logic [CW-1:0] remaining;

   logic          s_start = 1'b0;
   logic [3:0]    s_count = '0;
   logic [1:0]    s_prescale = '0;
   logic          s_busy, s_done, s_tick;
   logic [3:0]    s_rem;

   int n_checks = 0;
   int n_errors = 0;

   // Reference model: elapsed edges since launch, with D computed directly.
   int     m_state = 0;
   longint m_t = 0, m_d = 1, m_count = 0, m_pre = 0;
   bit     m_per = 1'b0;
   bit     m_tick = 1'b0;

   always #5 clk = ~clk;

   spi_prog_delay_timer #(.COUNT_WIDTH(CW), .PRESCALE_WIDTH(PW)) dut (
      .clock_i    (clk),
      .reset_ni   (rst_n),
      .start_i    (start),
      .abort_i    (abort),
      .count_i    (count),
      .prescale_i (prescale),
      .periodic_i (periodic),
      .busy_o     (busy),
      .done_o     (done),
      .tick_o     (tick),
      .remaining_o(remaining)
   );

   spi_prog_delay_timer #(.COUNT_WIDTH(4), .PRESCALE_WIDTH(2)) dut_small (
      .clock_i    (clk),
      .reset_ni   (rst_n),
      .start_i    (s_start),
      .abort_i    (1'b0),
      .count_i    (s_count),
      .prescale_i (s_prescale),
      .periodic_i (1'b0),
      .busy_o     (s_busy),
      .done_o     (s_done),
      .tick_o     (s_tick),
      .remaining_o(s_rem)
   );

   task automatic chk(input string tag, input logic [63:0] act, input logic [63:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_errors++;
         $display("FAIL %s: got %0d expected %0d (t=%0t)", tag, act, exp, $time);
      end
   endtask

   task automatic model_reset();
      m_state = 0;
      m_tick  = 1'b0;
   endtask

   task automatic model_edge();
      m_tick = 1'b0;
      if (m_state == 1) begin
         m_t++;
         if (abort) begin
            m_state = 0;
         end else if (m_t % m_d == 0) begin
            m_tick = 1'b1;
            if (!m_per) m_state = 2;
         end
      end else if (abort) begin
         m_state = 0;
      end else if (start) begin
         m_state = 1;
         m_t     = 0;
         m_count = longint'(count);
         m_pre   = longint'(prescale);
         m_per   = periodic;
         m_d     = (m_count == 0) ? 1 : m_count * (m_pre + 1);
      end
   endtask

   task automatic check_all(input string tag);
      longint rem;
      rem = 0;
      if (m_state == 1 && m_count != 0) rem = m_count - (m_t % m_d) / (m_pre + 1);
      chk({tag, ".busy"}, 64'(busy), 64'(m_state == 1));
      chk({tag, ".done"}, 64'(done), 64'(m_state == 2));
      chk({tag, ".tick"}, 64'(tick), 64'(m_tick));
      chk({tag, ".remaining"}, 64'(remaining), 64'(rem));
   endtask

   task automatic step(input string tag);
      @(posedge clk);
      if (rst_n) model_edge();
      #1;
      check_all(tag);
   endtask

   task automatic steps(input int n, input string tag);
      for (int i = 0; i < n; i++) step(tag);
   endtask

   task automatic launch(input int c, input int p, input bit per, input string tag);
      start    = 1'b1;
      count    = CW'(c);
      prescale = PW'(p);
      periodic = per;
      step(tag);
      start    = 1'b0;
   endtask

   task automatic do_abort(input string tag);
      abort = 1'b1;
      step(tag);
      abort = 1'b0;
   endtask

   initial begin
      #2;
      chk("reset.busy", 64'(busy), 64'(0));
      chk("reset.done", 64'(done), 64'(0));
      chk("reset.tick", 64'(tick), 64'(0));
      chk("reset.remaining", 64'(remaining), 64'(0));
      chk("reset.small_busy", 64'(s_busy), 64'(0));
      #10 rst_n = 1'b1;

      // One-shot, prescale 0
      launch(5, 0, 1'b0, "os5");
      steps(7, "os5");
      do_abort("os5_abort");
      steps(2, "os5_idle");

      // One-shot, prescale 3
      launch(3, 3, 1'b0, "os3p3");
      steps(14, "os3p3");
      do_abort("os3p3_abort");

      // Periodic, aborted at edge 20
      launch(4, 1, 1'b1, "per");
      steps(19, "per");
      do_abort("per_abort");
      steps(6, "per_after");

      // Zero count, then start+abort together in IDLE
      launch(0, 7, 1'b0, "zero");
      steps(2, "zero");
      do_abort("zero_abort");
      start = 1'b1;
      abort = 1'b1;
      step("start_abort_idle");
      start = 1'b0;
      abort = 1'b0;
      step("start_abort_idle");

      // Abort on the expiry edge
      launch(5, 0, 1'b0, "abort_exp");
      steps(4, "abort_exp");
      do_abort("abort_exp_edge");
      steps(3, "abort_exp_after");

      // Start while running is ignored; restart from DONE
      launch(6, 0, 1'b0, "retrig");
      start = 1'b1;
      count = CW'(2);
      steps(3, "retrig_ignored");
      start = 1'b0;
      steps(5, "retrig");
      launch(2, 1, 1'b0, "relaunch_done");
      steps(5, "relaunch_done");
      do_abort("relaunch_abort");

      // Asynchronous reset mid-run
      launch(9, 1, 1'b0, "rst_mid");
      steps(3, "rst_mid");
      #2 rst_n = 1'b0;
      #1;
      model_reset();
      check_all("rst_async");
      steps(2, "rst_held");
      #2 rst_n = 1'b1;
      launch(2, 0, 1'b0, "post_rst");
      steps(3, "post_rst");

      // Maximum count and prescale on the narrow instance
      s_count    = 4'd15;
      s_prescale = 2'd3;
      s_start    = 1'b1;
      step("small_launch");
      s_start = 1'b0;
      chk("small.busy0", 64'(s_busy), 64'(1));
      chk("small.rem0", 64'(s_rem), 64'(15));
      for (int t = 1; t <= 62; t++) begin
         step("small_idle_main");
         chk("small.tick", 64'(s_tick), 64'(t == 60));
         chk("small.busy", 64'(s_busy), 64'(t < 60));
         chk("small.done", 64'(s_done), 64'(t >= 60));
         chk("small.rem", 64'(s_rem), (t < 60) ? 64'(15 - t / 4) : 64'(0));
      end

      // Randomized traffic
      for (int i = 0; i < 3000; i++) begin
         start    = ($urandom % 4) == 0;
         abort    = ($urandom % 20) == 0;
         count    = (($urandom % 8) == 0) ? CW'($urandom % 40) : CW'($urandom % 8);
         prescale = PW'($urandom % 4);
         periodic = $urandom % 2;
         step("rand");
      end
      start = 1'b0;
      abort = 1'b0;

      $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
      $finish;
   end

   initial begin
      #500000;
      $display("FAIL watchdog: got timeout expected completion");
      n_errors++;
      $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
      $fatal(1, "watchdog expired");
   end

endmodule
